clk_div_ctrl: RTL and testbench

Runtime-configurable clock-enable divider controller. It owns the active divide value, accepts new values through a valid/ready handshake, and applies them only at a half-period boundary so the divided output never produces a runt phase. It keeps the established divider semantics: toggle when `count == N`, giving a half-period of N+1 clk cycles. It sits between the control logic (FSM or switch-decoding) and every consumer of a slow `clk_d` or its `tick` strobe.

---
 rtl/clk_div_ctrl.sv | 105 ++++++++++
 tb/tb_clk_div_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-configurable clock-enable divider controller.
// New divide values are applied only at half-period boundaries (no runt phases).
module clk_div_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_d,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] div_n;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] pend_div_n;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_n;
    logic             clk_d_n;
    logic             tick_n;
    logic             xfer;
    logic             term;

    assign cfg_ready = (state != PEND);
    assign busy      = (state != IDLE);
    assign xfer      = cfg_valid & cfg_ready;
    assign term      = busy & (count == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div      <= WIDTH'(DEFAULT_DIV);
            pend_div <= '0;
            count    <= '0;
            clk_d    <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state    <= state_n;
            div      <= div_n;
            pend_div <= pend_div_n;
            count    <= count_n;
            clk_d    <= clk_d_n;
            tick     <= tick_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_n      = div;
        pend_div_n = pend_div;
        count_n    = count;
        clk_d_n    = clk_d;
        tick_n     = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer) div_n = cfg_div;
                if (run) begin
                    state_n = RUN;
                    count_n = '0;
                end
            end
            RUN, PEND: begin
                // Stopping wins over a coincident terminal cycle.
                if (!run) begin
                    state_n = IDLE;
                    count_n = '0;
                    clk_d_n = 1'b0;
                    if (state == PEND) div_n = pend_div;
                    else if (xfer) div_n = cfg_div;
                end else if (term) begin
                    count_n = '0;
                    clk_d_n = ~clk_d;
                    tick_n  = 1'b1;
                    if (state == PEND) begin
                        div_n   = pend_div;
                        state_n = RUN;
                    end else if (xfer) begin
                        div_n = cfg_div;
                    end
                end else begin
                    count_n = count + 1'b1;
                    if (xfer) begin
                        pend_div_n = cfg_div;
                        state_n    = PEND;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: directed scenarios plus randomized traffic
// checked against a half-period-length reference model.
module tb_clk_div_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready;
    logic         clk_d;
    logic         tick;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: running flag, active N, optional pending N,
    // edges elapsed in the current half-period.
    bit m_on;
    bit m_pv;
    bit m_clk;
    bit m_tick;
    int m_n;
    int m_pend;
    int m_age;

    always #5 clk = ~clk;

    clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_d     (clk_d),
        .tick      (tick),
        .busy      (busy)
    );

    wire [3:0] d_vec = {clk_d, tick, busy, cfg_ready};

    function automatic logic [3:0] m_vec();
        return {m_clk, m_tick, m_on, !m_pv};
    endfunction

    task automatic model_reset();
        m_on = 0; m_pv = 0; m_clk = 0; m_tick = 0;
        m_n = 1; m_pend = 0; m_age = 0;
    endtask

    task automatic model_step();
        bit x;
        x = cfg_valid && !m_pv;
        if (rst) begin
            model_reset();
        end else if (!m_on) begin
            if (x) m_n = int'(cfg_div);
            if (run) begin
                m_on = 1;
                m_age = 0;
            end
        end else if (!run) begin
            if (m_pv) m_n = m_pend;
            else if (x) m_n = int'(cfg_div);
            m_on = 0; m_pv = 0; m_clk = 0; m_tick = 0; m_age = 0;
        end else begin
            m_age++;
            m_tick = (m_age == m_n + 1);
            if (m_tick) begin
                m_clk = !m_clk;
                m_age = 0;
                if (m_pv) begin
                    m_n = m_pend;
                    m_pv = 0;
                end else if (x) begin
                    m_n = int'(cfg_div);
                end
            end else if (x) begin
                m_pv = 1;
                m_pend = int'(cfg_div);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; run = 0; cfg_valid = 0;
        model_reset();
        adv(); adv();
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            adv();
            n_cmp++;
            if (d_vec !== 4'b0001) begin
                n_err++;
                $display("FAIL reset_idle: got %b want 0001", d_vec);
            end
        end
        run = 1;
        adv(); adv(); adv();
        n_cmp++;
        if (clk_d !== 1'b1) begin
            n_err++;
            $display("FAIL pre_async: clk_d=%b want 1", clk_d);
        end
        #2 rst = 1;
        #1;
        model_reset();
        n_cmp++;
        if ({clk_d, tick, busy, cfg_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL async_rst: got %b want 0001",
                     {clk_d, tick, busy, cfg_ready});
        end
        run = 0;
        #1 rst = 0;
    endtask

    task automatic test_default_div();
        logic [3:0] exp;
        run = 1;
        for (int k = 0; k <= 12; k++) begin
            adv();
            exp = {1'((k / 2) % 2), 1'(k > 0 && k % 2 == 0), 1'b1, 1'b1};
            n_cmp++;
            if (d_vec !== exp) begin
                n_err++;
                $display("FAIL div1 k=%0d: got %b want %b", k, d_vec, exp);
            end
            n_cmp++;
            if (d_vec !== m_vec()) begin
                n_err++;
                $display("FAIL div1_model k=%0d: got %b want %b", k, d_vec, m_vec());
            end
        end
    endtask

    task automatic test_reconfig();
        cfg_valid = 1; cfg_div = 3;
        adv();
        cfg_valid = 0;
        n_cmp++;
        if ({tick, cfg_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL recfg_accept: tick,ready=%b want 00", {tick, cfg_ready});
        end
        adv();
        n_cmp++;
        if ({tick, cfg_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL recfg_switch: tick,ready=%b want 11", {tick, cfg_ready});
        end
        for (int j = 1; j <= 8; j++) begin
            adv();
            n_cmp++;
            if (tick !== 1'(j % 4 == 0) || d_vec !== m_vec()) begin
                n_err++;
                $display("FAIL recfg_n3 j=%0d: got %b want %b", j, d_vec, m_vec());
            end
        end
    endtask

    task automatic test_terminal_cfg();
        for (int j = 0; j < 3; j++) adv();
        cfg_valid = 1; cfg_div = 5;
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL term_ready: got %b want 1", cfg_ready);
        end
        adv();
        cfg_valid = 0;
        n_cmp++;
        if ({tick, cfg_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL term_toggle: tick,ready=%b want 11", {tick, cfg_ready});
        end
        for (int j = 1; j <= 12; j++) begin
            adv();
            n_cmp++;
            if (tick !== 1'(j % 6 == 0) || d_vec !== m_vec()) begin
                n_err++;
                $display("FAIL term_n5 j=%0d: got %b want %b", j, d_vec, m_vec());
            end
        end
    endtask

    task automatic test_drop_run();
        for (int j = 0; j < 5; j++) adv();
        cfg_valid = 1; cfg_div = 3;
        adv();
        cfg_div = 7;
        adv();
        cfg_valid = 0;
        n_cmp++;
        if (cfg_ready !== 1'b0 || d_vec !== m_vec()) begin
            n_err++;
            $display("FAIL drop_pend: got %b want %b", d_vec, m_vec());
        end
        adv();
        run = 0;
        adv();
        n_cmp++;
        if (d_vec !== 4'b0001) begin
            n_err++;
            $display("FAIL drop_idle: got %b want 0001", d_vec);
        end
        run = 1;
        for (int k = 0; k <= 9; k++) begin
            adv();
            n_cmp++;
            if (tick !== 1'(k == 8) || clk_d !== 1'(k >= 8) || d_vec !== m_vec()) begin
                n_err++;
                $display("FAIL drop_n7 k=%0d: got %b want %b", k, d_vec, m_vec());
            end
        end
    endtask

    task automatic test_div_zero();
        run = 0;
        adv();
        cfg_valid = 1; cfg_div = 0; run = 1;
        adv();
        cfg_valid = 0;
        n_cmp++;
        if ({clk_d, tick} !== 2'b00) begin
            n_err++;
            $display("FAIL zero_entry: clk_d,tick=%b want 00", {clk_d, tick});
        end
        for (int k = 1; k <= 8; k++) begin
            adv();
            n_cmp++;
            if ({clk_d, tick} !== {1'(k % 2), 1'b1} || d_vec !== m_vec()) begin
                n_err++;
                $display("FAIL zero k=%0d: got %b want %b", k, d_vec, m_vec());
            end
        end
    endtask

    task automatic test_random();
        run = 1;
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(31) != 0);
            cfg_valid = ($urandom_range(7) == 0);
            cfg_div = W'($urandom_range(6));
            adv();
            n_cmp++;
            if (d_vec !== m_vec()) begin
                n_err++;
                $display("FAIL random i=%0d: got %b want %b", i, d_vec, m_vec());
            end
        end
        cfg_valid = 0;
    endtask

    task automatic test_max_div();
        run = 0;
        adv(); adv();
        cfg_valid = 1; cfg_div = 16'hFFFF; run = 1;
        adv();
        cfg_valid = 0;
        for (int k = 1; k <= 65537; k++) begin
            adv();
            n_cmp++;
            if (d_vec !== m_vec()) begin
                n_err++;
                $display("FAIL max_model k=%0d: got %b want %b", k, d_vec, m_vec());
            end
            if (k == 65535) begin
                n_cmp++;
                if ({clk_d, tick} !== 2'b00) begin
                    n_err++;
                    $display("FAIL max_top: clk_d,tick=%b want 00", {clk_d, tick});
                end
            end
            if (k == 65536) begin
                n_cmp++;
                if ({clk_d, tick} !== 2'b11) begin
                    n_err++;
                    $display("FAIL max_toggle: clk_d,tick=%b want 11", {clk_d, tick});
                end
            end
        end
        run = 0;
        adv();
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_reconfig();
        test_terminal_cfg();
        test_drop_run();
        test_div_zero();
        test_random();
        test_max_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
